// File: rtl/c_adder_tree_acc_if.sv
// c_adder_tree_acc_if: beat-input and packet-result handshake bundle for c_adder_tree_acc
// Signals:
//   in_valid/in_ready/in_last - beat handshake and end-of-packet tag
//   c0/c1                     - per-element LSBs and sign bits, element = c0 - 2*c1
//   out_valid/out_ready       - packet-result handshake
//   out_sum/out_ovf           - saturated packet total and sticky saturation flag
// Modports: master drives beats and consumes results, slave is the adder tree.
interface c_adder_tree_acc_if #(
    parameter int N_ELEM = 32,
    parameter int ACC_W  = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic [N_ELEM-1:0]       c0;
    logic [N_ELEM-1:0]       c1;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic                    out_ovf;
    modport master (
        output in_valid, in_last, c0, c1, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );
    modport slave (
        input  in_valid, in_last, c0, c1, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/c_adder_tree_acc.sv
// c_adder_tree_acc: pipelined signed 2-bit adder tree with saturating per-packet accumulator
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, discards in-flight beats and partial packets
//   bus   - slave side of c_adder_tree_acc_if (beat input, packet-result output)
module c_adder_tree_acc #(
    parameter int N_ELEM = 32,
    parameter int ACC_W  = 16
) (
    input logic               clk,
    input logic               rst_n,
    c_adder_tree_acc_if.slave bus
);
    localparam int L      = $clog2(N_ELEM);
    localparam int BEAT_W = L + 2;
    // Tree kept as a heap: node n sums heap[2n] and heap[2n+1]; leaves sit at N_ELEM..2*N_ELEM-1.
    // Registering every internal node gives exactly one register per tree level.
    logic signed [BEAT_W-1:0] node [1:N_ELEM-1];
    logic signed [BEAT_W-1:0] heap [2:2*N_ELEM-1];
    logic [L-1:0]             vld;
    logic [L-1:0]             lst;
    logic                     stall;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  clamped;
    logic signed [ACC_W:0]    sum;
    logic                     flag;
    logic                     ovf;
    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;
    always_comb begin
        for (int n = 2; n < N_ELEM; n++) heap[n] = node[n];
        for (int i = 0; i < N_ELEM; i++) heap[N_ELEM+i] = {{L{bus.c1[i]}}, bus.c1[i], bus.c0[i]};
    end
    // One guard bit above ACC_W is enough: a single add of two ACC_W-bit signed values cannot overflow it.
    assign sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(node[1]);
    assign ovf     = sum[ACC_W] ^ sum[ACC_W-1];
    assign clamped = ovf ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 1; n < N_ELEM; n++) node[n] <= '0;
            vld           <= '0;
            lst           <= '0;
            acc           <= '0;
            flag          <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_ovf   <= 1'b0;
        end else if (!stall) begin
            // Node values are carried at full beat width; pair sums never exceed the beat range.
            for (int n = 1; n < N_ELEM; n++) node[n] <= heap[2*n] + heap[2*n+1];
            vld           <= L'({vld, bus.in_valid});
            lst           <= L'({lst, bus.in_last});
            bus.out_valid <= vld[L-1] & lst[L-1];
            if (vld[L-1]) begin
                acc  <= lst[L-1] ? '0 : clamped;
                flag <= ~lst[L-1] & (flag | ovf);
                if (lst[L-1]) begin
                    bus.out_sum <= clamped;
                    bus.out_ovf <= flag | ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_c_adder_tree_acc.sv
// tb_c_adder_tree_acc: self-checking bench driving ACC_W=16 and ACC_W=8 instances with identical stimulus
module tb_c_adder_tree_acc;
    localparam int N = 32;
    localparam int L = 5;
    typedef struct { int s16; bit o16; int s8; bit o8; } exp_t;
    typedef struct { logic [N-1:0] c0; logic [N-1:0] c1; int sum; } vec_t;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [N-1:0] c0 = '0;
    logic [N-1:0] c1 = '0;
    logic         rdy_cmd = 1'b1;
    logic         rand_en = 1'b0;
    logic         rnd_rdy = 1'b1;
    logic         out_ready;
    int           checks = 0;
    int           errors = 0;
    int           acc16 = 0;
    int           acc8 = 0;
    bit           f16 = 0;
    bit           f8 = 0;
    exp_t         q[$];
    exp_t         e;
    bit           st;
    bit           prev_stall = 0;
    assign out_ready = rand_en ? rnd_rdy : rdy_cmd;
    c_adder_tree_acc_if #(.N_ELEM(N), .ACC_W(16)) a ();
    c_adder_tree_acc_if #(.N_ELEM(N), .ACC_W(8))  b ();
    assign a.in_valid  = in_valid;
    assign a.in_last   = in_last;
    assign a.c0        = c0;
    assign a.c1        = c1;
    assign a.out_ready = out_ready;
    assign b.in_valid  = in_valid;
    assign b.in_last   = in_last;
    assign b.c0        = c0;
    assign b.c1        = c1;
    assign b.out_ready = out_ready;
    c_adder_tree_acc #(.N_ELEM(N), .ACC_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    c_adder_tree_acc #(.N_ELEM(N), .ACC_W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b.slave));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic int sat(input int v, input int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction
    // Packet-level reference: beat sum from element values, saturating running total per width.
    task automatic accept();
        int bs = 0;
        int v;
        for (int i = 0; i < N; i++) bs += int'(c0[i]) - 2 * int'(c1[i]);
        v = acc16 + bs;
        acc16 = sat(v, 16);
        f16 |= (acc16 != v);
        v = acc8 + bs;
        acc8 = sat(v, 8);
        f8 |= (acc8 != v);
        if (in_last) begin
            q.push_back('{acc16, f16, acc8, f8});
            acc16 = 0; acc8 = 0; f16 = 0; f8 = 0;
        end
    endtask
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            acc16 = 0; acc8 = 0; f16 = 0; f8 = 0;
            q.delete();
        end else begin
            st = a.out_valid && !out_ready;
            chk("in_ready16", a.in_ready, !st);
            chk("in_ready8", b.in_ready, !(b.out_valid && !out_ready));
            if (prev_stall) chk("hold_valid", a.out_valid, 1);
            prev_stall = st;
            if (in_valid && a.in_ready) accept();
            if (a.out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("sum16", a.out_sum, e.s16);
                    chk("ovf16", a.out_ovf, e.o16);
                    chk("valid8", b.out_valid, 1);
                    chk("sum8", b.out_sum, e.s8);
                    chk("ovf8", b.out_ovf, e.o8);
                end
            end
        end
    end
    task automatic drive_beat(input logic [N-1:0] x0, input logic [N-1:0] x1, input logic last);
        int n = 0;
        bit ok;
        in_valid = 1'b1; c0 = x0; c1 = x1; in_last = last;
        do begin
            @(negedge clk);
            ok = a.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("accept_timeout", 0, 1);
        in_valid = 1'b0; c0 = $urandom; c1 = $urandom; in_last = 1'($urandom);
    endtask
    task automatic wait_out(output int n);
        n = 0;
        while (!a.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask
    // lat counts clock edges after the LAST beat's accepting edge; L edges means valid in cycle t+L+1.
    task automatic result(input string nm, input int lat, input int s16, input int o16, input int s8, input int o8);
        int n;
        wait_out(n);
        chk({nm, "_lat"}, n, lat);
        chk({nm, "_sum16"}, a.out_sum, s16);
        chk({nm, "_ovf16"}, a.out_ovf, o16);
        chk({nm, "_sum8"}, b.out_sum, s8);
        chk({nm, "_ovf8"}, b.out_ovf, o8);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid16", a.out_valid, 0);
        chk("rst_sum16", a.out_sum, 0);
        chk("rst_ovf16", a.out_ovf, 0);
        chk("rst_ready16", a.in_ready, 1);
        chk("rst_valid8", b.out_valid, 0);
        chk("rst_sum8", b.out_sum, 0);
        chk("rst_ready8", b.in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
    initial begin
        vec_t tv[8];
        int   got[$];
        int   b2b[3];
        int   n;
        int   len;
        tv[0] = '{32'h0000_0000, 32'hFFFF_FFFF, -64};
        tv[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32};
        tv[2] = '{32'h5555_5555, 32'hAAAA_AAAA, -16};
        tv[3] = '{32'h0000_0000, 32'h0000_0000, 0};
        tv[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, -32};
        tv[5] = '{32'h0000_FFFF, 32'h0000_0000, 16};
        tv[6] = '{32'h0000_0001, 32'h0000_0000, 1};
        tv[7] = '{32'h0000_0000, 32'h8000_0000, -2};
        b2b = '{32, -64, 1};
        #2;
        do_reset();
        drive_beat('0, '1, 1'b1);
        result("neg64", L, -64, 0, -64, 0);
        for (int k = 0; k < 4; k++) begin
            drive_beat(32'h0000_FFFF, '0, k == 3);
            chk("early_valid", a.out_valid, 0);
        end
        result("plus64", L, 64, 0, 64, 0);
        for (int k = 0; k < 3; k++) drive_beat('0, '1, k == 2);
        result("sat", L, -192, 0, -128, 1);
        drive_beat('1, '0, 1'b1);
        result("after_sat", L, 32, 0, 32, 0);
        for (int i = 0; i < 8; i++) begin
            drive_beat(tv[i].c0, tv[i].c1, 1'b1);
            result($sformatf("vec%0d", i), L, tv[i].sum, 0, tv[i].sum, 0);
        end
        drive_beat('1, '0, 1'b1);
        drive_beat('0, '1, 1'b1);
        drive_beat(32'h0000_0001, '0, 1'b1);
        wait_out(n);
        chk("b2b_lat", n, L - 2);
        rdy_cmd = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", a.in_ready, 0);
            chk("stall_valid", a.out_valid, 1);
            chk("stall_sum", a.out_sum, 32);
        end
        rdy_cmd = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (a.out_valid) got.push_back(a.out_sum);
            @(posedge clk);
            #1;
        end
        chk("b2b_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk($sformatf("b2b_%0d", i), got[i], b2b[i]);
        drive_beat(32'h0000_FFFF, '0, 1'b0);
        drive_beat(32'h0000_FFFF, '0, 1'b0);
        do_reset();
        drive_beat('1, '0, 1'b1);
        result("post_rst", L, 32, 0, 32, 0);
        rand_en = 1'b1;
        for (int p = 0; p < 60; p++) begin
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                drive_beat($urandom, $urandom, k == len - 1);
            end
        end
        rand_en = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
